// File: rtl/spram_tile_buffer_ctrl.sv
// Tile staging sequencer for a single-port RAM: fills from a valid/ready input
// stream, then drains the same words in address order through a 2-entry skid buffer.
module spram_tile_buffer_ctrl #(
   parameter int AWIDTH    = 11,
   parameter int DWIDTH    = 40,
   parameter int NUM_WORDS = 2048
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [AWIDTH:0]   length,
   output logic              busy,
   output logic              done,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DWIDTH-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DWIDTH-1:0] out_data,
   output logic [AWIDTH-1:0] ram_address,
   output logic              ram_wren,
   output logic [DWIDTH-1:0] ram_data,
   input  logic [DWIDTH-1:0] ram_out
);

   typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

   localparam logic [AWIDTH:0] MAX_LEN = (AWIDTH+1)'(NUM_WORDS);

   state_t            state, state_nx;
   logic [AWIDTH:0]   len, wptr, rptr, pcnt, len_sat;
   logic              rd_pend, issue, pop;
   logic [DWIDTH-1:0] skid [2];
   logic              skid_wr, skid_rd;
   logic [1:0]        skid_cnt;
   logic [2:0]        inflight;

   assign len_sat   = (length > MAX_LEN) ? MAX_LEN : length;
   assign out_valid = (skid_cnt != 2'd0);
   assign out_data  = skid[skid_rd];
   assign pop       = out_valid && out_ready;

   // A pop this cycle frees a slot in time for a read issued now, which keeps
   // the drain at one word per cycle while never holding more than 2 in flight.
   assign inflight = 3'(rd_pend) + 3'(skid_cnt) - 3'(pop);
   assign issue    = (state == DRAIN) && (inflight < 3'd2) && (rptr < len);

   always_comb begin
      state_nx    = state;
      busy        = (state != IDLE);
      done        = 1'b0;
      in_ready    = 1'b0;
      ram_wren    = 1'b0;
      ram_address = '0;
      ram_data    = '0;
      case (state)
         IDLE: begin
            if (start) state_nx = (len_sat == '0) ? DONE : FILL;
         end
         FILL: begin
            in_ready    = 1'b1;
            ram_address = wptr[AWIDTH-1:0];
            if (in_valid) begin
               ram_wren = 1'b1;
               ram_data = in_data;
               if (wptr == len - 1'b1) state_nx = DRAIN;
            end
         end
         DRAIN: begin
            ram_address = rptr[AWIDTH-1:0];
            if (pop && (pcnt == len - 1'b1)) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         len      <= '0;
         wptr     <= '0;
         rptr     <= '0;
         pcnt     <= '0;
         rd_pend  <= 1'b0;
         skid[0]  <= '0;
         skid[1]  <= '0;
         skid_wr  <= 1'b0;
         skid_rd  <= 1'b0;
         skid_cnt <= '0;
      end else begin
         state   <= state_nx;
         rd_pend <= issue;
         if (state == IDLE && start) begin
            len  <= len_sat;
            wptr <= '0;
            rptr <= '0;
            pcnt <= '0;
         end
         if (state == FILL && in_valid) wptr <= wptr + 1'b1;
         if (issue) rptr <= rptr + 1'b1;
         // Read data lands on ram_out the cycle after issue.
         if (rd_pend) begin
            skid[skid_wr] <= ram_out;
            skid_wr       <= ~skid_wr;
         end
         if (pop) begin
            skid_rd <= ~skid_rd;
            pcnt    <= pcnt + 1'b1;
         end
         skid_cnt <= skid_cnt + 2'(rd_pend) - 2'(pop);
      end
   end

endmodule

// File: tb/tb_spram_tile_buffer_ctrl.sv
// Directed table-driven bench for spram_tile_buffer_ctrl with a behavioural
// 2048x40 single-port RAM attached to the RAM pins.
module tb_spram_tile_buffer_ctrl;

   localparam int AW = 11;
   localparam int DW = 40;
   localparam int NW = 2048;
   localparam int BUDGET = 20000;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW:0]   length;
   logic          busy, done;
   logic          in_valid, in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid, out_ready;
   logic [DW-1:0] out_data;
   logic [AW-1:0] ram_address;
   logic          ram_wren;
   logic [DW-1:0] ram_data;
   logic [DW-1:0] ram_out = '0;

   always #5 clk = ~clk;

   spram_tile_buffer_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .NUM_WORDS(NW)) dut (
      .clk(clk), .reset(reset), .start(start), .length(length),
      .busy(busy), .done(done),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .ram_address(ram_address), .ram_wren(ram_wren), .ram_data(ram_data),
      .ram_out(ram_out)
   );

   logic [DW-1:0] mem [NW];
   always @(posedge clk) begin
      if (ram_wren) mem[ram_address] <= ram_data;
      else          ram_out <= mem[ram_address];
   end

   typedef struct {
      int          len;
      int          exp_n;
      logic [DW-1:0] base;
      logic [DW-1:0] step;
      bit          gap;
      int          bp;
      bit          spur;
   } vec_t;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic do_start(input int len);
      @(negedge clk);
      start  = 1'b1;
      length = (AW+1)'(len);
      @(negedge clk);
      start  = 1'b0;
      length = '0;
   endtask

   task automatic run(input vec_t v, input int abort_after);
      int done_cnt = 0;
      do_start(v.len);
      fork
         begin : producer
            int  i = 0;
            int  cyc = 0;
            bit  tog = 1'b1;
            logic [DW-1:0] d;
            while (i < v.exp_n && cyc < BUDGET) begin
               d        = v.base + DW'(i) * v.step;
               in_valid = v.gap ? tog : 1'b1;
               in_data  = d;
               tog      = ~tog;
               #1;
               if (in_valid && in_ready) begin
                  chk("wr_en", 64'(ram_wren), 64'd1);
                  chk("wr_addr", 64'(ram_address), 64'(i % NW));
                  chk("wr_data", 64'(ram_data), 64'(d));
                  i++;
               end else if (!in_valid) begin
                  chk("wr_idle", 64'(ram_wren), 64'd0);
               end
               @(negedge clk);
               cyc++;
            end
            in_valid = 1'b0;
            if (i < v.exp_n) chk("fill_timeout", 64'(i), 64'(v.exp_n));
         end
         begin : consumer
            int  k = 0;
            int  cyc = 0;
            int  post = -1;
            int  first = 0;
            int  last = 0;
            int  done_cyc = -1;
            bit  prev_stall = 1'b0;
            bit  spur_done = 1'b0;
            logic [DW-1:0] prev_data = '0;
            while (cyc < BUDGET) begin
               start = 1'b0;
               if (v.spur && k == 2 && !spur_done) begin
                  start     = 1'b1;
                  length    = (AW+1)'(3);
                  spur_done = 1'b1;
               end
               out_ready = (v.bp == 0) || ($urandom_range(99) >= 32'(v.bp));
               #1;
               if (done) begin
                  done_cnt++;
                  if (done_cyc < 0) done_cyc = cyc;
               end
               if (v.exp_n == 0) chk("len0_no_wr", 64'(ram_wren), 64'd0);
               if (prev_stall) begin
                  chk("stall_valid", 64'(out_valid), 64'd1);
                  chk("stall_data", 64'(out_data), 64'(prev_data));
               end
               if (out_valid && out_ready) begin
                  chk("out_data", 64'(out_data), 64'(v.base + DW'(k) * v.step));
                  if (k == 0) first = cyc;
                  last = cyc;
                  k++;
               end
               prev_stall = out_valid && !out_ready;
               prev_data  = out_data;
               if (abort_after > 0 && k == abort_after) break;
               if (done && post < 0) post = 0;
               @(negedge clk);
               cyc++;
               if (post >= 0) begin
                  post++;
                  if (post > 2) break;
               end
            end
            start     = 1'b0;
            out_ready = 1'b0;
            if (abort_after == 0) begin
               if (post < 0) chk("drain_timeout", 64'd0, 64'd1);
               chk("word_count", 64'(k), 64'(v.exp_n));
               chk("done_once", 64'(done_cnt), 64'd1);
               chk("busy_end", 64'(busy), 64'd0);
               if (v.exp_n == 0) chk("len0_done_cycle", 64'(done_cyc), 64'd0);
               if (v.bp == 0 && v.exp_n > 0) chk("throughput", 64'(last - first), 64'(v.exp_n - 1));
            end
         end
      join
   endtask

   vec_t tbl[7];
   vec_t hv;

   initial begin
      tbl[0] = '{len: 4,    exp_n: 4,    base: 40'hA0,          step: 40'h1,  gap: 0, bp: 0,  spur: 0};
      tbl[1] = '{len: 8,    exp_n: 8,    base: 40'hB0,          step: 40'h1,  gap: 1, bp: 0,  spur: 0};
      tbl[2] = '{len: 16,   exp_n: 16,   base: 40'h100,         step: 40'h3,  gap: 0, bp: 30, spur: 0};
      tbl[3] = '{len: 2048, exp_n: 2048, base: 40'hAB_0000_0000, step: 40'h1,  gap: 0, bp: 0,  spur: 0};
      tbl[4] = '{len: 3000, exp_n: 2048, base: 40'h7,           step: 40'h5,  gap: 0, bp: 0,  spur: 0};
      tbl[5] = '{len: 0,    exp_n: 0,    base: 40'h0,           step: 40'h1,  gap: 0, bp: 0,  spur: 0};
      tbl[6] = '{len: 6,    exp_n: 6,    base: 40'hC0,          step: 40'h1,  gap: 0, bp: 0,  spur: 1};

      reset = 1'b1; start = 1'b0; length = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_wren", 64'(ram_wren), 64'd0);
      chk("rst_addr", 64'(ram_address), 64'd0);
      chk("rst_ram_data", 64'(ram_data), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;

      for (int t = 0; t < 7; t++) run(tbl[t], 0);

      // Reset in the middle of the drain, then a fresh short transaction.
      hv = '{len: 10, exp_n: 10, base: 40'h300, step: 40'h1, gap: 0, bp: 0, spur: 0};
      run(hv, 5);
      reset = 1'b1;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      hv = '{len: 2, exp_n: 2, base: 40'h11, step: 40'h11, gap: 0, bp: 0, spur: 0};
      run(hv, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
